operand_arbiter_4: RTL and testbench

OPERAND_ARBITER_4 -- requirements
Module: operand_arbiter_4

---
 rtl/operand_arb_pkg.sv | 10 +
 rtl/rr_pick4.sv | 27 ++
 rtl/operand_arbiter_4.sv | 109 ++++++++++
 tb/tb_operand_arbiter_4.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_arb_pkg.sv
// Shared types and sizes for the 4-way operand arbiter.
package operand_arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: first set request bit at or after ptr, wrapping modulo 4.
// Latency: purely combinational.
// Backpressure: none; consumer decides when idx is used.
module rr_pick4
    import operand_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;

    always_comb begin
        dbl = {req, req};
        // rot[k] is request (ptr + k) mod 4
        rot = dbl[ptr +: NUM_REQ];
        any = |req;
        idx = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = ptr + SEL_W'(k);
            end
        end
    end
endmodule

// File: rtl/operand_arbiter_4.sv
// operand_arbiter_4: 4-way burst arbiter feeding one registered operand stage; OPERAND_ARB_FIXED_PRIO_EN selects fixed priority.
// Latency: one arbitration bubble in IDLE, then accepted beat appears on out_data the next cycle.
// Backpressure: holder's req_ready = !out_valid | out_ready; out_data holds while stalled.
module operand_arbiter_4
    import operand_arb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req_valid,
    input  logic [WIDTH-1:0] in_data_0,
    input  logic [WIDTH-1:0] in_data_1,
    input  logic [WIDTH-1:0] in_data_2,
    input  logic [WIDTH-1:0] in_data_3,
    output logic [3:0]       req_ready,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);
    localparam int               CNT_W     = $clog2(BURST) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt, pick_idx;
    logic [CNT_W-1:0] beat_cnt;
    logic             pick_any, out_free, xfer;
    logic [WIDTH-1:0] sel_data;

    // In fixed-priority builds ptr never moves off 0, so the picker degrades to index-0-first.
    rr_pick4 u_pick (
        .req (req_valid),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        case (sel)
            2'd0:    sel_data = in_data_0;
            2'd1:    sel_data = in_data_1;
            2'd2:    sel_data = in_data_2;
            default: sel_data = in_data_3;
        endcase
    end

    assign out_free = !out_valid || out_ready;
    assign busy     = (state == GRANT);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        req_ready = '0;
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (rst_n) begin
                    req_ready[sel] = out_free;
                end
                xfer = req_valid[sel] && out_free;
                if (!req_valid[sel] || (xfer && beat_cnt == LAST_BEAT)) begin
                    state_nxt = IDLE;
`ifdef OPERAND_ARB_FIXED_PRIO_EN
                    ptr_nxt   = '0;
`else
                    ptr_nxt   = sel + 1'b1;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            if (state == IDLE && pick_any) begin
                sel      <= pick_idx;
                beat_cnt <= '0;
            end
            if (xfer) begin
                out_data  <= sel_data;
                out_valid <= 1'b1;
                // Final beat releases the grant; saturate so the count stays within BURST-1.
                if (beat_cnt != LAST_BEAT) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_operand_arbiter_4.sv
// Bench for operand_arbiter_4: directed scenarios plus randomized traffic against a transaction-level model.
module tb_operand_arbiter_4;
    localparam int WIDTH = 16;
    localparam int BURST = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req_valid;
    logic [WIDTH-1:0] din [4];
    logic [3:0]       req_ready;
    logic [1:0]       sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             busy;

    always #5 clk = ~clk;

    operand_arbiter_4 #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .in_data_0 (din[0]),
        .in_data_1 (din[1]),
        .in_data_2 (din[2]),
        .in_data_3 (din[3]),
        .req_ready (req_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    int errors = 0;
    int checks = 0;

    // Logs gathered by the observer below; the test tasks compare them against expectations.
    logic [WIDTH-1:0] in_q[$], out_q[$];
    logic [3:0]       dec_q[$];
    int               grant_q[$], beats_q[$], exp_q[$], gap_q[$];
    int               cur_beats, idle_cnt, ready_bad;
    int               rem [4];
    logic             prev_busy;
    logic [3:0]       last_req, hs_v, exp_rdy;

    initial begin
        prev_busy = 1'b0;
        last_req  = '0;
        hs_v      = '0;
        cur_beats = 0;
        idle_cnt  = 0;
        ready_bad = 0;
        forever begin
            @(negedge clk);
            exp_rdy = (rst_n && busy && (!out_valid || out_ready)) ? (4'b0001 << sel) : 4'b0000;
            if (req_ready !== exp_rdy) ready_bad++;
            hs_v = rst_n ? (req_valid & req_ready) : 4'b0000;
            if (prev_busy && !busy) beats_q.push_back(cur_beats);
            if (rst_n && busy && !prev_busy) begin
                grant_q.push_back(int'(sel));
                dec_q.push_back(last_req);
                exp_q.push_back(rem[sel] < BURST ? rem[sel] : BURST);
                gap_q.push_back(idle_cnt);
                cur_beats = 0;
            end
            if (hs_v != 4'b0000) begin
                in_q.push_back(din[sel]);
                cur_beats++;
            end
            if (rst_n && out_valid && out_ready) out_q.push_back(out_data);
            idle_cnt  = busy ? 0 : idle_cnt + 1;
            last_req  = req_valid;
            prev_busy = rst_n && busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    function automatic int model_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        in_q.delete(); out_q.delete(); dec_q.delete(); grant_q.delete();
        beats_q.delete(); exp_q.delete(); gap_q.delete();
        cur_beats = 0;
        idle_cnt  = 0;
        ready_bad = 0;
    endtask

    task automatic do_reset();
        to_drive();
        rst_n = 1'b0;
        req_valid = 4'b0000;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        to_drive();
        rst_n = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        to_sample();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_async: got %b expected 0000", req_ready); end
        to_drive();
        to_sample();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
        checks++; if (dut.ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr: got %0d expected 0", dut.ptr); end
        checks++; if (int'(dut.beat_cnt) != 0) begin errors++; $display("FAIL reset_beat_cnt: got %0d expected 0", dut.beat_cnt); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        to_drive();
        rst_n = 1'b1;
        req_valid = 4'b0000;
        clear_logs();
    endtask

    task automatic test_single_burst();
        logic [WIDTH-1:0] v [4];
        int j = 0;
        for (int i = 0; i < 4; i++) v[i] = WIDTH'($urandom);
        do_reset();
        for (int k = 0; k < 16; k++) begin
            to_drive();
            if (hs_v[2]) j++;
            req_valid = (j < 4) ? 4'b0100 : 4'b0000;
            din[2]    = (j < 4) ? v[j] : '0;
            to_sample();
            if (k == 0) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_bubble: busy got %b expected 0", busy); end
            end
            if (k == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_grant_busy: got %b expected 1", busy); end
                checks++; if (sel !== 2'd2) begin errors++; $display("FAIL single_grant_sel: got %0d expected 2", sel); end
            end
        end
        checks++;
        if (beats_q.size() != 1 || out_q.size() != 4) begin
            errors++; $display("FAIL single_counts: grants_ended=%0d outputs=%0d expected 1 and 4", beats_q.size(), out_q.size());
        end else begin
            checks++; if (beats_q[0] != 4) begin errors++; $display("FAIL single_beats: got %0d expected 4", beats_q[0]); end
            for (int i = 0; i < 4; i++) begin
                checks++; if (out_q[i] !== v[i]) begin errors++; $display("FAIL single_data[%0d]: got %h expected %h", i, out_q[i], v[i]); end
            end
        end
`ifdef OPERAND_ARB_FIXED_PRIO_EN
        checks++; if (dut.ptr !== 2'd0) begin errors++; $display("FAIL single_ptr: got %0d expected 0", dut.ptr); end
`else
        checks++; if (dut.ptr !== 2'd3) begin errors++; $display("FAIL single_ptr: got %0d expected 3", dut.ptr); end
`endif
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        int exp_g [5];
`ifdef OPERAND_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0, 0};
`else
        exp_g = '{0, 1, 2, 3, 0};
`endif
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) din[i] = WIDTH'($urandom);
        for (int k = 0; k < 60 && beats_q.size() < 5; k++) begin
            to_drive();
            for (int i = 0; i < 4; i++) if (hs_v[i]) din[i] = WIDTH'($urandom);
            to_sample();
        end
        to_drive();
        req_valid = 4'b0000;
        repeat (6) to_sample();
        checks++;
        if (grant_q.size() < 5 || beats_q.size() < 5) begin
            errors++; $display("FAIL rr_progress: grants=%0d ended=%0d expected at least 5", grant_q.size(), beats_q.size());
        end else begin
            for (int g = 0; g < 5; g++) begin
                checks++; if (grant_q[g] != exp_g[g]) begin errors++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", g, grant_q[g], exp_g[g]); end
                checks++; if (beats_q[g] != BURST) begin errors++; $display("FAIL rr_beats[%0d]: got %0d expected %0d", g, beats_q[g], BURST); end
                if (g > 0) begin
                    checks++; if (gap_q[g] != 1) begin errors++; $display("FAIL rr_bubble[%0d]: got %0d expected 1", g, gap_q[g]); end
                end
            end
        end
        checks++; if (ready_bad != 0) begin errors++; $display("FAIL rr_ready_rule: got %0d bad cycles expected 0", ready_bad); end
        checks++; if (out_q.size() != in_q.size()) begin errors++; $display("FAIL rr_beat_total: got %0d outputs expected %0d", out_q.size(), in_q.size()); end
        for (int i = 0; i < out_q.size() && i < in_q.size(); i++) begin
            checks++; if (out_q[i] !== in_q[i]) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", i, out_q[i], in_q[i]); end
        end
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] v [4];
        logic [WIDTH-1:0] last_acc = '0;
        int j = 0, stall = 0, stall_seen = 0;
        bit seen = 0;
        for (int i = 0; i < 4; i++) v[i] = WIDTH'($urandom);
        do_reset();
        for (int k = 0; k < 30; k++) begin
            to_drive();
            if (hs_v[1]) begin last_acc = v[j]; j++; end
            req_valid = (j < 4) ? 4'b0010 : 4'b0000;
            din[1]    = (j < 4) ? v[j] : '0;
            out_ready = (stall == 0);
            if (stall > 0) stall--;
            to_sample();
            if (!seen && out_valid) begin seen = 1; stall = 3; end
            if (!out_ready && out_valid) begin
                stall_seen++;
                checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b expected 0", req_ready[1]); end
                checks++; if (out_data !== last_acc) begin errors++; $display("FAIL stall_hold: got %h expected %h", out_data, last_acc); end
            end
        end
        out_ready = 1'b1;
        checks++; if (stall_seen != 3) begin errors++; $display("FAIL stall_cycles: got %0d expected 3", stall_seen); end
        checks++;
        if (beats_q.size() != 1 || out_q.size() != 4) begin
            errors++; $display("FAIL stall_counts: grants_ended=%0d outputs=%0d expected 1 and 4", beats_q.size(), out_q.size());
        end else begin
            checks++; if (beats_q[0] != 4) begin errors++; $display("FAIL stall_beats: got %0d expected 4", beats_q[0]); end
            for (int i = 0; i < 4; i++) begin
                checks++; if (out_q[i] !== v[i]) begin errors++; $display("FAIL stall_data[%0d]: got %h expected %h", i, out_q[i], v[i]); end
            end
        end
    endtask

    task automatic test_early_release();
        int j = 0;
        bit rel_seen = 0, was_busy = 0;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            to_drive();
            if (hs_v[3] || k == 0) din[3] = WIDTH'($urandom);
            if (hs_v[3]) j++;
            req_valid = (j < 2) ? 4'b1000 : 4'b0000;
            to_sample();
            if (was_busy && !busy && !rel_seen) begin
                rel_seen = 1;
                checks++; if (int'(dut.beat_cnt) != 2) begin errors++; $display("FAIL early_beat_cnt: got %0d expected 2", dut.beat_cnt); end
                checks++; if (dut.ptr !== 2'd0) begin errors++; $display("FAIL early_ptr: got %0d expected 0", dut.ptr); end
            end
            was_busy = busy;
        end
        checks++; if (!rel_seen) begin errors++; $display("FAIL early_release: got no release expected release within 20 cycles"); end
        checks++; if (grant_q.size() != 1 || grant_q[0] != 3) begin errors++; $display("FAIL early_grant: got %0d grants expected one to requester 3", grant_q.size()); end
        checks++; if (out_q.size() != 2 || in_q.size() != 2) begin errors++; $display("FAIL early_beats: got %0d outputs expected 2", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < in_q.size(); i++) begin
            checks++; if (out_q[i] !== in_q[i]) begin errors++; $display("FAIL early_data[%0d]: got %h expected %h", i, out_q[i], in_q[i]); end
        end
    endtask

    task automatic test_reset_mid_grant();
        int j = 0;
        bit fired = 0, done = 0;
        do_reset();
        din[2] = WIDTH'($urandom);
        for (int k = 0; k < 20 && !done; k++) begin
            to_drive();
            if (hs_v[2]) begin j++; din[2] = WIDTH'($urandom); end
            if (j == 1 && !fired) begin rst_n = 1'b0; fired = 1; end
            else rst_n = 1'b1;
            req_valid = 4'b0100;
            to_sample();
            if (!rst_n) begin
                checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready_in_reset: got %b expected 0000", req_ready); end
            end else if (fired) begin
                done = 1;
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
                checks++; if (dut.ptr !== 2'd0) begin errors++; $display("FAIL midrst_ptr: got %0d expected 0", dut.ptr); end
                checks++; if (sel !== 2'd0) begin errors++; $display("FAIL midrst_sel: got %0d expected 0", sel); end
                checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready: got %b expected 0000", req_ready); end
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL midrst_reached: got no mid-grant reset expected one"); end
        req_valid = 4'b0000;
    endtask

    task automatic test_two_requesters();
        int exp_g [4];
`ifdef OPERAND_ARB_FIXED_PRIO_EN
        exp_g = '{1, 1, 1, 1};
`else
        exp_g = '{1, 3, 1, 3};
`endif
        do_reset();
        req_valid = 4'b1010;
        for (int k = 0; k < 80 && beats_q.size() < 4; k++) begin
            to_drive();
            for (int i = 0; i < 4; i++) if (hs_v[i]) din[i] = WIDTH'($urandom);
            to_sample();
        end
        to_drive();
        req_valid = 4'b0000;
        repeat (4) to_sample();
        checks++;
        if (grant_q.size() < 4) begin
            errors++; $display("FAIL pair_progress: got %0d grants expected at least 4", grant_q.size());
        end else begin
            for (int g = 0; g < 4; g++) begin
                checks++; if (grant_q[g] != exp_g[g]) begin errors++; $display("FAIL pair_grant[%0d]: got %0d expected %0d", g, grant_q[g], exp_g[g]); end
            end
        end
        checks++; if (ready_bad != 0) begin errors++; $display("FAIL pair_ready_rule: got %0d bad cycles expected 0", ready_bad); end
    endtask

    task automatic test_random();
        int n_done, mptr = 0, w;
        do_reset();
        for (int i = 0; i < 4; i++) rem[i] = 0;
        for (int k = 0; k < 600; k++) begin
            to_drive();
            for (int i = 0; i < 4; i++) begin
                if (hs_v[i]) begin
                    rem[i]--;
                    din[i] = WIDTH'($urandom);
                end else if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
                    rem[i] = int'($urandom_range(1, 7));
                    din[i] = WIDTH'($urandom);
                end
                req_valid[i] = (rem[i] != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            to_sample();
        end
        n_done = beats_q.size();
        to_drive();
        for (int i = 0; i < 4; i++) rem[i] = 0;
        req_valid = 4'b0000;
        out_ready = 1'b1;
        repeat (20) to_sample();
        checks++; if (n_done < 10) begin errors++; $display("FAIL rand_progress: got %0d grants expected at least 10", n_done); end
        for (int g = 0; g < grant_q.size(); g++) begin
            w = model_pick(dec_q[g], mptr);
            checks++; if (grant_q[g] != w) begin errors++; $display("FAIL rand_grant[%0d]: got %0d expected %0d", g, grant_q[g], w); end
`ifndef OPERAND_ARB_FIXED_PRIO_EN
            mptr = (w + 1) % 4;
`endif
            checks++; if (gap_q[g] < 1) begin errors++; $display("FAIL rand_bubble[%0d]: got %0d expected >=1", g, gap_q[g]); end
            if (g < n_done) begin
                checks++; if (beats_q[g] != exp_q[g]) begin errors++; $display("FAIL rand_beats[%0d]: got %0d expected %0d", g, beats_q[g], exp_q[g]); end
            end
        end
        checks++; if (ready_bad != 0) begin errors++; $display("FAIL rand_ready_rule: got %0d bad cycles expected 0", ready_bad); end
        checks++; if (out_q.size() != in_q.size()) begin errors++; $display("FAIL rand_beat_total: got %0d outputs expected %0d", out_q.size(), in_q.size()); end
        for (int i = 0; i < out_q.size() && i < in_q.size(); i++) begin
            checks++; if (out_q[i] !== in_q[i]) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, out_q[i], in_q[i]); end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din[i] = '0;
            rem[i] = 100;
        end
        test_reset();
        test_single_burst();
        test_round_robin();
        test_stall();
        test_early_release();
        test_reset_mid_grant();
        test_two_requesters();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
